// File: rtl/tns_decoder_09_pipe_pkg.sv
// tns_decoder_09_pipe_pkg
//   Shared types, weights and helpers for the 9-wire TNS decoder.
//   The TNS weight macros normally come from the shared TNS.vh header.
//   If that header has not been read first, the fallback values below are
//   used. They are the Fibonacci weights of the 9-bit TNS code, so a
//   valid codeword decodes to at most 88.
//   Optional feature macro: TNS_XTALK_CHECK_EN (checked by the top level).

`ifndef TNS03_A
`define TNS03_A 55
`define TNS03_B 34
`define TNS03_C 21
`define TNS02_A 13
`define TNS02_B 8
`define TNS02_C 5
`define TNS01_A 3
`define TNS01_B 2
`define BLEN03  7
`endif

package tns_decoder_09_pipe_pkg;

    localparam int DW          = `BLEN03;
    localparam int CW          = 9;
    localparam int NUM_GRP     = 3;
    localparam int XTALK_PAIRS = 8;

    typedef logic [DW-1:0] data_t;
    typedef logic [CW-1:0] code_t;

    // Weight of bit b (0 = LSB) inside group g (0 = wires 2:0).
    function automatic data_t grp_weight(input int g, input int b);
        data_t w;
        w = data_t'(1);
        case (g)
            0: case (b)
                   0:       w = data_t'(1);
                   1:       w = data_t'(`TNS01_B);
                   default: w = data_t'(`TNS01_A);
               endcase
            1: case (b)
                   0:       w = data_t'(`TNS02_C);
                   1:       w = data_t'(`TNS02_B);
                   default: w = data_t'(`TNS02_A);
               endcase
            default: case (b)
                   0:       w = data_t'(`TNS03_C);
                   1:       w = data_t'(`TNS03_B);
                   default: w = data_t'(`TNS03_A);
               endcase
        endcase
        return w;
    endfunction

    // Opposite transitions on a pair of adjacent wires between two beats.
    function automatic logic xtalk_viol(input code_t prev, input code_t cur);
        logic v;
        v = 1'b0;
        for (int i = 0; i < XTALK_PAIRS; i++) begin
            v |= (prev[i] ^ cur[i]) & (prev[i+1] ^ cur[i+1]) & (cur[i] ^ cur[i+1]);
        end
        return v;
    endfunction

endpackage

// File: rtl/tns_decoder_09_pipe_group_sum.sv
// tns_group_sum
//   Combinational weighted sum of one 3-wire TNS group.
//   slice : 3-bit group slice of the codeword
//   w2..w0: weights of slice[2]..slice[0]
//   sum   : partial sum, truncated to the data width

module tns_group_sum
    import tns_decoder_09_pipe_pkg::*;
(
    input  logic [2:0] slice,
    input  data_t      w2,
    input  data_t      w1,
    input  data_t      w0,
    output data_t      sum
);

    always_comb begin
        sum = (slice[2] ? w2 : '0) + (slice[1] ? w1 : '0) + (slice[0] ? w0 : '0);
    end

endmodule

// File: rtl/tns_decoder_09_pipe.sv
// tns_decoder_09_pipe
//   Two-stage receiver decoder for the 9-wire TNS link.
//   Stage 1 registers three group partial sums (and the crosstalk flag),
//   stage 2 registers their total. Both sides use valid/ready.
//   Ports:
//     clock, rst_n                   clock, async active-low reset
//     code_in/code_valid/code_ready  9-bit codeword input
//     data_out/data_valid/data_ready decoded word output
//     err_xtalk                      crosstalk flag aligned with data_out
//     err_cnt                        saturating count of flagged beats delivered
//   Optional feature macro: TNS_XTALK_CHECK_EN. When undefined the checker
//   is absent and err_xtalk/err_cnt are tied to zero.

module tns_decoder_09_pipe
    import tns_decoder_09_pipe_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic [CW-1:0]    code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic [DW-1:0]    data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             err_xtalk,
    output logic [CNT_W-1:0] err_cnt
);

    logic                           s1_valid_q, s1_valid_d;
    logic [NUM_GRP-1:0][DW-1:0]     grp_q, grp_d, grp_sum;
    data_t                          data_q, data_d;
    logic                           data_valid_q, data_valid_d;
    logic                           s2_accept, in_hs, s1_move;

    // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
    assign s2_accept  = ~data_valid_q | data_ready;
    assign code_ready = ~s1_valid_q | s2_accept;
    assign in_hs      = code_valid & code_ready;
    assign s1_move    = s1_valid_q & s2_accept;

    for (genvar g = 0; g < NUM_GRP; g++) begin : gen_grp
        tns_group_sum u_grp (
            .slice (code_in[3*g +: 3]),
            .w2    (grp_weight(g, 2)),
            .w1    (grp_weight(g, 1)),
            .w0    (grp_weight(g, 0)),
            .sum   (grp_sum[g])
        );
    end

    always_comb begin
        s1_valid_d   = in_hs | (s1_valid_q & ~s2_accept);
        grp_d        = in_hs ? grp_sum : grp_q;
        data_valid_d = s2_accept ? s1_valid_q : data_valid_q;
        data_d       = data_q;
        if (s1_move) begin
            data_d = grp_q[2] + grp_q[1] + grp_q[0];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            grp_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            grp_q        <= grp_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = data_valid_q;

`ifdef TNS_XTALK_CHECK_EN
    code_t            prev_code_q, prev_code_d;
    logic             s1_err_q, s1_err_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_code_d = prev_code_q;
        s1_err_d    = s1_err_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if (in_hs) begin
            prev_code_d = code_in;
            s1_err_d    = xtalk_viol(prev_code_q, code_in);
        end
        if (s1_move) begin
            err_d = s1_err_q;
        end
        // Count on the output handshake; hold at all-ones.
        if (data_valid_q && data_ready && err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_code_q <= '0;
            s1_err_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            prev_code_q <= prev_code_d;
            s1_err_q    <= s1_err_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign err_xtalk = err_q;
    assign err_cnt   = cnt_q;
`else
    assign err_xtalk = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_tns_decoder_09_pipe.sv
// tb_tns_decoder_09_pipe
//   Directed bench for tns_decoder_09_pipe. Inputs change on the falling
//   edge; outputs are sampled shortly after it. Crosstalk expectations
//   follow TNS_XTALK_CHECK_EN (zero when the checker is compiled out).

module tb_tns_decoder_09_pipe;

`ifdef TNS_XTALK_CHECK_EN
    localparam bit XT = 1'b1;
`else
    localparam bit XT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [6:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       err_xtalk;
    logic [7:0] err_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    tns_decoder_09_pipe #(.CNT_W(8)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .err_xtalk  (err_xtalk),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n      = 1'b0;
        code_valid = 1'b0;
        #2;
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_data_out",   32'(data_out),   0);
        chk("rst_err_xtalk",  32'(err_xtalk),  0);
        chk("rst_err_cnt",    32'(err_cnt),    0);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // One isolated word through an empty pipe with data_ready=1.
    task automatic send_chk(input string tag, input logic [8:0] code,
                            input logic [6:0] exp_d, input logic exp_e,
                            input logic [7:0] exp_cnt);
        code_valid = 1'b1;
        code_in    = code;
        #1 chk({tag, "_ready"}, 32'(code_ready), 1);
        @(negedge clock);
        code_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(data_valid), 0);
        @(negedge clock);
        chk({tag, "_lat2"}, 32'(data_valid), 1);
        chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
        chk({tag, "_xtalk"}, 32'(err_xtalk), 32'(exp_e));
        @(negedge clock);
        chk({tag, "_drained"}, 32'(data_valid), 0);
        chk({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] words [5];
        logic [6:0] exp_w [5];
        int in_idx, out_idx;
        bit stall, hold_v;
        logic [6:0] hold_d;

        // 1: zero and one
        apply_reset();
        data_ready = 1'b1;
        send_chk("t1_w0", 9'h000, 7'd0, 1'b0, 8'd0);
        send_chk("t1_w1", 9'h001, 7'd1, 1'b0, 8'd0);

        // 2: MSB group A plus group-1 B weight = 55 + 2
        apply_reset();
        send_chk("t2", 9'b100000010, 7'd57, 1'b0, 8'd0);

        // 3: opposite transitions on wires 0/1, then a repeat
        apply_reset();
        send_chk("t3_a", 9'b000000001, 7'd1, 1'b0, 8'd0);
        send_chk("t3_b", 9'b000000010, 7'd2, XT, 8'(XT));
        send_chk("t3_c", 9'b000000010, 7'd2, 1'b0, 8'(XT));

        // 4: five-word stream with data_ready low in cycles 3..6
        apply_reset();
        words = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010};
        exp_w = '{7'd1, 7'd2, 7'd3, 7'd5, 7'd8};
        in_idx = 0; out_idx = 0; stall = 0; hold_v = 0; hold_d = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            data_ready = !(c >= 3 && c <= 6);
            code_valid = (in_idx < 5);
            code_in    = (in_idx < 5) ? words[in_idx] : 9'h000;
            #1;
            if (hold_v) chk("t4_hold", 32'(data_out), 32'(hold_d));
            hold_v = data_valid && !data_ready;
            hold_d = data_out;
            if (data_valid && data_ready) begin
                if (out_idx < 5) chk("t4_order", 32'(data_out), 32'(exp_w[out_idx]));
                else chk("t4_extra", out_idx, 4);
                out_idx++;
            end
            if (code_valid && !code_ready) stall = 1;
            if (code_valid && code_ready) in_idx++;
        end
        code_valid = 1'b0;
        data_ready = 1'b1;
        chk("t4_count", out_idx, 5);
        chk("t4_stall", 32'(stall), 1);

        // 5: 300 violating beats (the first beat is clean) -> saturate
        apply_reset();
        for (int n = 0; n < 301; n++) begin
            @(negedge clock);
            code_valid = 1'b1;
            code_in    = (n % 2 == 0) ? 9'h001 : 9'h002;
            #1 if (!code_ready) chk("t5_ready", 32'(code_ready), 1);
        end
        @(negedge clock);
        code_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("t5_flushed", 32'(data_valid), 0);
        chk("t5_sat", 32'(err_cnt), XT ? 255 : 0);

        // 6: reset with two words in flight
        @(negedge clock);
        data_ready = 1'b0;
        code_valid = 1'b1;
        code_in    = 9'h001;
        @(negedge clock);
        code_in    = 9'h002;
        @(negedge clock);
        code_valid = 1'b0;
        #1 chk("t6_inflight", 32'(data_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_dv_async", 32'(data_valid), 0);
        chk("t6_cnt_clr",  32'(err_cnt), 0);
        @(negedge clock);
        rst_n = 1'b1;
        data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("t6_no_stale", 32'(data_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
